// File: rtl/lap_memory_ctrl.sv
// Lap-time store controller: circular buffer of saved times with a display pointer.
// Optional `LAP_DELTA_EN adds disp_delta (selected entry minus next older entry).
module lap_memory_ctrl #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TIME_W = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clear,
    input  logic                       wr_req,
    input  logic [TIME_W-1:0]          wr_time,
    input  logic                       rd_restart,
    input  logic                       rd_req,
    output logic [TIME_W-1:0]          disp_time,
    output logic [$clog2(DEPTH)-1:0]   disp_idx,
    output logic                       disp_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       busy,
    output logic                       req_drop
`ifdef LAP_DELTA_EN
    ,
    output logic [TIME_W-1:0]          disp_delta
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

    state_t             state;
    logic [TIME_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_off;
    logic [AW-1:0]      clr_idx;
    logic [CW-1:0]      cnt;
    logic [TIME_W-1:0]  wr_data;
    logic               rd_step;
    logic [AW-1:0]      sel;
    logic               at_oldest;

    // Offset 0 is the newest entry, i.e. the slot just behind wr_ptr.
    assign sel        = wr_ptr - AW'(1) - rd_off;
    assign at_oldest  = ((CW'(rd_off) + CW'(1)) == cnt);

    assign count      = cnt;
    assign full       = (cnt == CW'(DEPTH));
    assign disp_valid = (cnt != '0);
    assign disp_idx   = rd_off;
    assign busy       = (state != IDLE);
    assign disp_time  = disp_valid ? mem[sel] : '0;

`ifdef LAP_DELTA_EN
    always_comb begin
        disp_delta = '0;
        if (disp_valid) begin
            if (at_oldest) disp_delta = mem[sel];
            else           disp_delta = mem[sel] - mem[sel - AW'(1)];
        end
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_off   <= '0;
            clr_idx  <= '0;
            cnt      <= '0;
            wr_data  <= '0;
            rd_step  <= 1'b0;
            req_drop <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            req_drop <= 1'b0;
            if (clear) begin
                // Clear wins everywhere; an in-flight write/read never commits.
                state    <= CLEAR;
                cnt      <= '0;
                wr_ptr   <= '0;
                rd_off   <= '0;
                clr_idx  <= '0;
                req_drop <= wr_req | rd_restart | rd_req;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_req) begin
                            state    <= WRITE;
                            wr_data  <= wr_time;
                            req_drop <= rd_restart | rd_req;
                        end else if (rd_restart) begin
                            state    <= READ;
                            rd_step  <= 1'b0;
                            req_drop <= rd_req;
                        end else if (rd_req) begin
                            state    <= READ;
                            rd_step  <= 1'b1;
                        end
                    end
                    WRITE: begin
                        mem[wr_ptr] <= wr_data;
                        wr_ptr      <= wr_ptr + AW'(1);
                        if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
                        rd_off      <= '0;
                        state       <= IDLE;
                        req_drop    <= wr_req | rd_restart | rd_req;
                    end
                    READ: begin
                        // rd_off < cnt always holds, so wrap is a compare, not a modulo.
                        if (!rd_step || cnt == '0 || at_oldest) rd_off <= '0;
                        else                                    rd_off <= rd_off + AW'(1);
                        state    <= IDLE;
                        req_drop <= wr_req | rd_restart | rd_req;
                    end
                    CLEAR: begin
                        mem[clr_idx] <= '0;
                        if (clr_idx == AW'(DEPTH - 1)) state <= IDLE;
                        else                           clr_idx <= clr_idx + AW'(1);
                        req_drop <= wr_req | rd_restart | rd_req;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lap_memory_ctrl.sv
// Bench for lap_memory_ctrl: directed cases plus random operations against a queue model.
module tb_lap_memory_ctrl;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TIME_W = 16;
    localparam int unsigned AW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              nrst;
    logic              clear, wr_req, rd_restart, rd_req;
    logic [TIME_W-1:0] wr_time;
    logic [TIME_W-1:0] disp_time;
    logic [AW-1:0]     disp_idx;
    logic              disp_valid;
    logic [AW:0]       count;
    logic              full, busy, req_drop;
`ifdef LAP_DELTA_EN
    logic [TIME_W-1:0] disp_delta;
`endif

    lap_memory_ctrl #(.DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
        .clk(clk), .nrst(nrst), .clear(clear), .wr_req(wr_req), .wr_time(wr_time),
        .rd_restart(rd_restart), .rd_req(rd_req), .disp_time(disp_time),
        .disp_idx(disp_idx), .disp_valid(disp_valid), .count(count), .full(full),
        .busy(busy), .req_drop(req_drop)
`ifdef LAP_DELTA_EN
        , .disp_delta(disp_delta)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: stored laps oldest..newest, plus display offset from newest.
    int unsigned q[$];
    int          off;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int unsigned exp_time();
        if (q.size() == 0) return 0;
        return q[q.size() - 1 - off];
    endfunction

    function automatic int unsigned exp_delta();
        int unsigned s;
        int unsigned cur;
        s = q.size();
        if (s == 0) return 0;
        cur = q[s - 1 - off];
        if (off == int'(s) - 1) return cur;
        return (cur - q[s - 2 - off]) & 32'hFFFF;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".time"},  32'(disp_time),  exp_time());
        check_eq({tag, ".idx"},   32'(disp_idx),   32'(off));
        check_eq({tag, ".valid"}, 32'(disp_valid), 32'(q.size() != 0));
        check_eq({tag, ".count"}, 32'(count),      32'(q.size()));
        check_eq({tag, ".full"},  32'(full),       32'(q.size() == DEPTH));
        check_eq({tag, ".busy"},  32'(busy),       32'(0));
`ifdef LAP_DELTA_EN
        check_eq({tag, ".delta"}, 32'(disp_delta), exp_delta());
`endif
    endtask

    // One request cycle; clr_after>0 pulses clear after that many busy samples,
    // poke pulses a wr_req during the first busy cycle.
    task automatic op(input bit c, input bit w, input bit rs, input bit rr,
                      input logic [TIME_W-1:0] v, input int clr_after, input bit poke);
        int n;
        int exp_busy;
        bit any;
        bit drop;
        @(negedge clk);
        clear = c; wr_req = w; wr_time = v; rd_restart = rs; rd_req = rr;
        @(negedge clk);
        clear = 1'b0; wr_req = 1'b0; rd_restart = 1'b0; rd_req = 1'b0;
        any  = c | w | rs | rr;
        drop = (int'(c) + int'(w) + int'(rs) + int'(rr)) > 1;
        check_eq("req_drop", 32'(req_drop), 32'(drop));
        check_eq("busy_start", 32'(busy), 32'(any));

        if (c || (any && clr_after > 0)) begin
            q.delete();
            off = 0;
        end else if (w) begin
            q.push_back(int'(v));
            if (q.size() > DEPTH) void'(q.pop_front());
            off = 0;
        end else if (rs) begin
            off = 0;
        end else if (rr && q.size() > 0) begin
            off = (off + 1) % q.size();
        end

        if (!any)          exp_busy = 0;
        else if (clr_after > 0) exp_busy = clr_after + int'(DEPTH);
        else if (c)        exp_busy = int'(DEPTH);
        else               exp_busy = 1;

        n = 0;
        while (busy === 1'b1 && n < 4 * int'(DEPTH)) begin
            n++;
            if (n == clr_after) clear = 1'b1;
            if (n == 1 && poke) begin wr_req = 1'b1; wr_time = 16'hDEAD; end
            @(negedge clk);
            if (n == 1 && poke) check_eq("drop_busy", 32'(req_drop), 32'(1));
            clear = 1'b0; wr_req = 1'b0;
        end
        check_eq("busy_cycles", 32'(n), 32'(exp_busy));
        check_state("after_op");
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        q.delete();
        off = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int r;
        logic [TIME_W-1:0] v;
        clear = 0; wr_req = 0; rd_restart = 0; rd_req = 0; wr_time = '0;
        q.delete(); off = 0;
        do_reset();
        repeat (5) @(negedge clk);
        check_state("reset");
        check_eq("reset.drop", 32'(req_drop), 32'(0));

        // Three writes, then step back through them with wrap.
        op(0, 1, 0, 0, 16'd10, 0, 0);
        op(0, 1, 0, 0, 16'd20, 0, 0);
        op(0, 1, 0, 0, 16'd30, 0, 0);
        check_eq("newest30", 32'(disp_time), 32'd30);
        op(0, 0, 0, 1, '0, 0, 0);
        check_eq("step20", 32'(disp_time), 32'd20);
        op(0, 0, 0, 1, '0, 0, 0);
        op(0, 0, 0, 1, '0, 0, 0);
        check_eq("wrap30", 32'(disp_time), 32'd30);

        // Overflow: 1..9 leaves 2..9.
        op(1, 0, 0, 0, '0, 0, 0);
        for (int i = 1; i <= 9; i++) op(0, 1, 0, 0, 16'(i), 0, 0);
        check_eq("full", 32'(full), 32'(1));
        for (int i = 0; i < 7; i++) op(0, 0, 0, 1, '0, 0, 0);
        check_eq("oldest2", 32'(disp_time), 32'd2);

        // Simultaneous write and read: write wins, read dropped.
        op(0, 1, 0, 1, 16'd77, 0, 0);
        check_eq("simul_idx", 32'(disp_idx), 32'(0));
        op(0, 0, 1, 1, '0, 0, 0);

        // Clear aborting a write, clear restarting a sweep, busy drop.
        op(0, 1, 0, 0, 16'd55, 1, 0);
        check_eq("abort_cnt", 32'(count), 32'(0));
        op(0, 0, 0, 1, '0, 0, 0);
        op(0, 1, 0, 0, 16'd5, 0, 1);
        op(1, 0, 0, 0, '0, 3, 1);

`ifdef LAP_DELTA_EN
        op(0, 1, 0, 0, 16'd100, 0, 0);
        op(0, 1, 0, 0, 16'd250, 0, 0);
        check_eq("delta150", 32'(disp_delta), 32'd150);
        op(0, 0, 0, 1, '0, 0, 0);
        check_eq("delta100", 32'(disp_delta), 32'd100);
`endif

        // Reset in the middle of a write.
        op(0, 1, 0, 0, 16'd9, 0, 0);
        @(negedge clk); wr_req = 1'b1; wr_time = 16'd123;
        @(negedge clk); wr_req = 1'b0; nrst = 1'b0;
        #1;
        check_eq("rst_mid.count", 32'(count), 32'(0));
        check_eq("rst_mid.busy", 32'(busy), 32'(0));
        @(negedge clk); nrst = 1'b1;
        q.delete(); off = 0;
        @(negedge clk);
        check_state("rst_mid");

        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 99));
            v = 16'($urandom);
            if (r < 40)      op(0, 1, 0, $urandom_range(0, 3) == 0, v, 0, $urandom_range(0, 4) == 0);
            else if (r < 65) op(0, 0, 0, 1, v, 0, $urandom_range(0, 4) == 0);
            else if (r < 75) op(0, 0, 1, $urandom_range(0, 1) == 1, v, 0, 0);
            else if (r < 80) op(1, 0, 0, 0, v, int'($urandom_range(0, DEPTH - 1)), 0);
            else if (r < 85) op(0, 1, 0, 0, v, 1, 0);
            else if (r < 95) op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), v, 0, 0);
            else             op(0, 0, 0, 0, v, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
